// File: rtl/pipe_shift.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake on both sides.
// Define PIPE_SHIFT_ROTATE_EN to enable ROR on in_op=11; otherwise in_op=11 executes as SRL.
module pipe_shift #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sticky
);

  localparam int AW    = $clog2(WIDTH);
  localparam int BASE  = AW / STAGES;
  localparam int EXTRA = AW % STAGES;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = {<<{d}};
    return r;
  endfunction

  // One binary right-shift step; SLL arrives here bit-reversed, so it shares the zero-fill path.
  function automatic logic [WIDTH-1:0] rshift_step(input logic [WIDTH-1:0] d, input int sh,
                                                   input logic [1:0] op, input logic sign);
    logic [WIDTH-1:0] fill_m;
    logic [WIDTH-1:0] r;
    fill_m = ~({WIDTH{1'b1}} >> sh);
    case (op)
      OP_SRA:  r = (d >> sh) | (sign ? fill_m : {WIDTH{1'b0}});
`ifdef PIPE_SHIFT_ROTATE_EN
      OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
`endif
      default: r = d >> sh;
    endcase
    return r;
  endfunction

  function automatic logic drop_sticky(input logic [WIDTH-1:0] d, input int sh,
                                       input logic [1:0] op);
    logic [WIDTH-1:0] low_m;
    logic             r;
    low_m = ~({WIDTH{1'b1}} << sh);
    case (op)
      OP_SRL, OP_SRA: r = |(d & low_m);
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  logic [1:0]       ent_op;
  logic [WIDTH-1:0] ent_data;

  // Entry transform: op remap when rotate is compiled out, bit reversal for SLL.
  always_comb begin
`ifdef PIPE_SHIFT_ROTATE_EN
    ent_op = in_op;
`else
    ent_op = (in_op == OP_ROR) ? OP_SRL : in_op;
`endif
    ent_data = (ent_op == OP_SLL) ? bit_rev(in_data) : in_data;
  end

  logic [STAGES-1:0] st_valid;
  logic [WIDTH-1:0]  st_data   [STAGES];
  logic [AW-1:0]     st_amt    [STAGES];
  logic [1:0]        st_op     [STAGES];
  logic              st_sign   [STAGES];
  logic              st_sticky [STAGES];
  logic [STAGES-1:0] adv;

  // Advance chain: a stage moves when empty or when its successor moves.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~st_valid[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = ~st_valid[i] | adv[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int  N       = BASE + ((i < EXTRA) ? 1 : 0);
    localparam int  S       = i * BASE + ((i < EXTRA) ? i : EXTRA);
    localparam bit  IS_LAST = (i == STAGES - 1);

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [AW-1:0]    src_amt;
    logic [1:0]       src_op;
    logic             src_sign;
    logic             src_sticky;

    logic             valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [AW-1:0]    amt_q;
    logic [1:0]       op_q;
    logic             sign_q;
    logic             sticky_d, sticky_q;
    logic [AW-1:0]    amt_m;
    logic             take_s;

    if (i == 0) begin : g_src_in
      assign src_valid  = in_valid;
      assign src_data   = ent_data;
      assign src_amt    = in_amt;
      assign src_op     = ent_op;
      assign src_sign   = in_data[WIDTH-1];
      assign src_sticky = 1'b0;
    end else begin : g_src_prev
      assign src_valid  = st_valid[i-1];
      assign src_data   = st_data[i-1];
      assign src_amt    = st_amt[i-1];
      assign src_op     = st_op[i-1];
      assign src_sign   = st_sign[i-1];
      assign src_sticky = st_sticky[i-1];
    end

    // Binary steps owned by this register (largest amount first), exit reversal on the last one.
    always_comb begin
      data_d   = src_data;
      sticky_d = src_sticky;
      amt_m    = '0;
      take_s   = 1'b0;
      for (int j = S; j < S + N; j++) begin
        amt_m    = {{(AW-1){1'b0}}, 1'b1} << (AW - 1 - j);
        take_s   = |(src_amt & amt_m);
        sticky_d = sticky_d | (take_s & drop_sticky(data_d, 32'sd1 << (AW - 1 - j), src_op));
        data_d   = take_s ? rshift_step(data_d, 32'sd1 << (AW - 1 - j), src_op, src_sign)
                          : data_d;
      end
      data_d = (IS_LAST && (src_op == OP_SLL)) ? bit_rev(data_d) : data_d;
    end

    // Stage register: payload only loads behind a valid operand.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q  <= 1'b0;
        data_q   <= '0;
        amt_q    <= '0;
        op_q     <= 2'b00;
        sign_q   <= 1'b0;
        sticky_q <= 1'b0;
      end else if (adv[i]) begin
        valid_q <= src_valid;
        if (src_valid) begin
          data_q   <= data_d;
          amt_q    <= src_amt;
          op_q     <= src_op;
          sign_q   <= src_sign;
          sticky_q <= sticky_d;
        end
      end
    end

    assign st_valid[i]  = valid_q;
    assign st_data[i]   = data_q;
    assign st_amt[i]    = amt_q;
    assign st_op[i]     = op_q;
    assign st_sign[i]   = sign_q;
    assign st_sticky[i] = sticky_q;
  end

  assign in_ready   = adv[0];
  assign out_valid  = st_valid[STAGES-1];
  assign out_data   = st_data[STAGES-1];
  assign out_sticky = st_sticky[STAGES-1];

endmodule

// File: tb/tb_pipe_shift.sv
// Randomized self-checking bench for pipe_shift (WIDTH=32, STAGES=2) against a queue-based
// arithmetic reference model.
module tb_pipe_shift;
  localparam int W  = 32;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [4:0]    in_amt = '0;
  logic [1:0]    in_op = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_sticky;

  typedef struct {
    logic [31:0] d;
    logic        s;
    int          c;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;

  pipe_shift #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain shifts on the whole operand.
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    exp_t        e;
    logic [31:0] lost;
    lost = d & ~(32'hFFFF_FFFF << a);
    e.c  = cyc;
    case (op)
      2'b00: begin e.d = d << a; e.s = 1'b0; end
      2'b10: begin e.d = 32'($signed(d) >>> a); e.s = |lost; end
`ifdef PIPE_SHIFT_ROTATE_EN
      2'b11: begin e.d = (d >> a) | (d << (32 - int'(a))); e.s = 1'b0; end
`endif
      default: begin e.d = d >> a; e.s = |lost; end
    endcase
    return e;
  endfunction

  // Scoreboard: compare whenever a result is presented (covers stall stability), pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check_eq("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check_eq("out_data", out_data, expq[0].d);
          check_eq("out_sticky", 32'(out_sticky), 32'(expq[0].s));
          if (out_ready) begin
            if (lat_chk) check_eq("latency", 32'(cyc - expq[0].c), 32'(ST));
            void'(expq.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) expq.push_back(model(in_data, in_amt, in_op));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    bit acc;
    int guard;
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end
    check_eq("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int guard;
    in_valid = 1'b0; out_ready = 1'b1; guard = 0;
    while (expq.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Isolated operation with hand-computed expectations and exact 2-cycle timing.
  task automatic single(input string tag, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] op, input logic [31:0] ed, input logic es);
    push(d, a, op);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, out_data, ed);
    check_eq({tag, "_sticky"}, 32'(out_sticky), 32'(es));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base_out;
    repeat (3) tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_sticky", 32'(out_sticky), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    single("sra_req", 32'h8000_0010, 5'd4, 2'b10, 32'hF800_0001, 1'b0);
    single("srl_req", 32'h0000_000F, 5'd3, 2'b01, 32'h0000_0001, 1'b1);
    single("sll_req", 32'h0000_000F, 5'd31, 2'b00, 32'h8000_0000, 1'b0);
`ifdef PIPE_SHIFT_ROTATE_EN
    single("ror_req", 32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000, 1'b0);
`else
    single("ror_req", 32'h0000_0001, 5'd1, 2'b11, 32'h0000_0000, 1'b1);
`endif
    single("amt0_srl", 32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back stream, no backpressure: every result exactly ST cycles after acceptance.
    lat_chk = 1'b1;
    push(32'h1234_5678, 5'd8, 2'b00);
    push(32'h8765_4321, 5'd16, 2'b10);
    push(32'hFFFF_FFFF, 5'd31, 2'b01);
    push(32'h0F0F_0F0F, 5'd7, 2'b11);
    push(32'h8000_0000, 5'd31, 2'b10);
    drain();
    lat_chk = 1'b0;

    // 8 back-to-back operands with a 5-cycle output stall mid-stream.
    base_out = n_out;
    fork
      begin
        for (int k = 0; k < 8; k++) push($urandom, 5'($urandom), 2'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (3) tick();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check_eq("stall_in_ready", 32'(in_ready), 32'd0);
          check_eq("stall_out_valid", 32'(out_valid), 32'd1);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("stream_count", 32'(n_out - base_out), 32'd8);

    // Reset with two operations in flight.
    push(32'hAAAA_5555, 5'd3, 2'b01);
    push(32'h5555_AAAA, 5'd5, 2'b10);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("inflight_rst_valid", 32'(out_valid), 32'd0);
    check_eq("inflight_rst_data", out_data, 32'd0);
    expq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("no_stale", 32'(out_valid), 32'd0);
    end
    tick();
    single("post_rst", 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b0);

    // Randomized traffic with random backpressure and edge amounts.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      case ($urandom_range(0, 3))
        0:       in_amt = 5'd0;
        1:       in_amt = 5'd31;
        default: in_amt = 5'($urandom);
      endcase
      in_op     = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_shift.md
PIPE_SHIFT -- requirements
Module: pipe_shift

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter STAGES, default 2, number of register stages; SHALL be 1..log2(WIDTH).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  input operand valid.
REQ-006 Port in_ready  output  1  block accepts the operand this cycle.
REQ-007 Port in_data  input  WIDTH  operand.
REQ-008 Port in_amt  input  log2(WIDTH)  shift amount, 0..WIDTH-1.
REQ-009 Port in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  downstream accepts the result.
REQ-012 Port out_data  output  WIDTH  shifted result.
REQ-013 Port out_sticky  output  1  OR of all bits shifted out on SRL/SRA.

Function
REQ-014 The block SHALL implement log2(WIDTH) binary stages, amounts 2^(k-1) down to 1, MSB of in_amt first, partitioned as evenly as possible over STAGES registers, earlier registers taking any extra binary stage.
REQ-015 Left and right shifts SHALL share one right-shift datapath, using bit reversal at entry and exit for SLL.
REQ-016 SLL SHALL zero-fill LSBs; SRL SHALL zero-fill MSBs; SRA SHALL fill MSBs with in_data[WIDTH-1] captured at acceptance.
REQ-017 ROR SHALL wrap bits shifted out of bit 0 into the MSB (see REQ-031).
REQ-018 Each register stage SHALL carry valid, partial data, remaining amount bits, op, sign and a partial sticky bit.
REQ-019 out_sticky SHALL be 1 iff any 1 bit was discarded on SRL/SRA; SHALL be 0 for SLL, ROR and for amount 0.
REQ-020 An operand accepted (in_valid and in_ready) SHALL appear on out_data exactly STAGES cycles later when no backpressure occurs.
REQ-021 Stage i SHALL advance when it is empty or stage i+1 advances; the last stage advances when out_ready=1 or out_valid=0.
REQ-022 in_ready SHALL equal the advance condition of stage 0; bubbles SHALL be collapsed.
REQ-023 With out_valid=1 and out_ready=0, out_data, out_sticky and out_valid SHALL hold stable.
REQ-024 Full throughput of one result per cycle SHALL be sustained while out_ready=1.
REQ-025 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-026 in_data, in_amt and in_op SHALL be ignored when in_valid=0.

Reset
REQ-027 rst_n low SHALL asynchronously clear all stage valid bits, giving out_valid=0.
REQ-028 On reset, out_data SHALL be 0 and out_sticky SHALL be 0.
REQ-029 Operations in flight when reset asserts SHALL be discarded.
REQ-030 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Configuration
REQ-031 Macro PIPE_SHIFT_ROTATE_EN defined: in_op=11 SHALL perform ROR as in REQ-017; macro undefined: in_op=11 SHALL execute as SRL, and the wrap logic SHALL be absent.

Verification
REQ-032 WIDTH=32, STAGES=2, SRA of 0x80000010 by 4, out_ready=1 -> out_data 0xF8000001, sticky 0, out_valid exactly 2 cycles after acceptance.
REQ-033 SRL of 0x0000000F by 3 -> out_data 0x00000001, sticky 1; SLL of 0x0000000F by 31 -> 0x80000000, sticky 0.
REQ-034 With PIPE_SHIFT_ROTATE_EN, ROR of 0x00000001 by 1 -> 0x80000000; without the macro, the same stimulus -> 0x00000000, sticky 1.
REQ-035 Stream 8 back-to-back operands, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 once both stages are full, output stable, all 8 results in order, no loss.
REQ-036 Assert rst_n low with 2 operations in flight -> out_valid=0 immediately; no stale result after release; next operand's result correct.
